detector_jogada: RTL and testbench



---
 rtl/detector_jogada_pkg.sv | 17 +
 rtl/detector_jogada_sincronizador_2ff.sv | 26 ++
 rtl/detector_jogada.sv | 143 ++++++++++++++
 tb/tb_detector_jogada.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/detector_jogada_pkg.sv
// Shared definitions for the play detector: FSM state codes and the one-hot check
// that the game's control unit also reuses.
package detector_jogada_pkg;

  typedef enum logic [2:0] {
    ESPERA   = 3'd0,
    FILTRA   = 3'd1,
    REGISTRA = 3'd2,
    SOLTA    = 3'd3
  } estado_t;

  // Exactly one bit set; zero is not a valid play.
  function automatic logic eh_one_hot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/detector_jogada_sincronizador_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; both stages reset to 0.
module sincronizador_2ff #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sinc_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sinc_q <= '0;
    end else begin
      meta_q <= d;
      sinc_q <= meta_q;
    end
  end

  assign q = sinc_q;

endmodule

// File: rtl/detector_jogada.sv
// Turns raw push buttons into debounced single-cycle play events (valid / invalid / timeout).
// Optional idle timeout enabled by defining DETECTOR_TIMEOUT_EN.
module detector_jogada
  import detector_jogada_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = 5000,
  parameter int TIMEOUT_CICLOS  = 3000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic [3:0] botoes,
  output logic [3:0] jogada,
  output logic       jogada_feita,
  output logic       jogada_invalida,
  output logic       timeout,
  output logic [2:0] db_estado
);

  localparam int MAX_C = (DEBOUNCE_CICLOS > TIMEOUT_CICLOS) ? DEBOUNCE_CICLOS : TIMEOUT_CICLOS;
  localparam int CW    = $clog2(MAX_C + 1);
  localparam logic [CW-1:0] DEB_FIM = CW'(DEBOUNCE_CICLOS - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;
`ifdef DETECTOR_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_FIM = CW'(TIMEOUT_CICLOS - 1);
`endif

  logic [3:0]    s_botoes;
  estado_t       estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    snap_q, snap_d;
  logic [3:0]    jogada_q, jogada_d;
  logic          feita_q, feita_d;
  logic          inval_q, inval_d;
  logic          timeout_q, timeout_d;

  sincronizador_2ff #(.W(4)) u_sinc (
    .clock (clock),
    .reset (reset),
    .d     (botoes),
    .q     (s_botoes)
  );

  // Saturating so the timeout can never fire a second time.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= SOLTA;
      cnt_q     <= '0;
      snap_q    <= 4'b0000;
      jogada_q  <= 4'b0000;
      feita_q   <= 1'b0;
      inval_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      snap_q    <= snap_d;
      jogada_q  <= jogada_d;
      feita_q   <= feita_d;
      inval_q   <= inval_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    snap_d    = snap_q;
    jogada_d  = jogada_q;
    feita_d   = 1'b0;
    inval_d   = 1'b0;
    timeout_d = 1'b0;
    case (estado_q)
      SOLTA: begin
        if (s_botoes != 4'b0000) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_FIM) begin
          estado_d = ESPERA;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ESPERA: begin
        // A press in the same cycle as the timeout wins.
        if (habilita && (s_botoes != 4'b0000)) begin
          snap_d   = s_botoes;
          cnt_d    = '0;
          estado_d = FILTRA;
`ifdef DETECTOR_TIMEOUT_EN
        end else if (habilita) begin
          cnt_d     = cnt_inc;
          timeout_d = (cnt_q == TMO_FIM);
`endif
        end else begin
          cnt_d = '0;
        end
      end
      FILTRA: begin
        if (!habilita) begin
          estado_d = SOLTA;
          cnt_d    = '0;
        end else if (s_botoes == 4'b0000) begin
          estado_d = ESPERA;
          cnt_d    = '0;
        end else if (s_botoes != snap_q) begin
          snap_d = s_botoes;
          cnt_d  = '0;
        end else if (cnt_q == DEB_FIM) begin
          estado_d = REGISTRA;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      REGISTRA: begin
        estado_d = SOLTA;
        cnt_d    = '0;
        if (habilita) begin
          if (eh_one_hot(snap_q)) begin
            jogada_d = snap_q;
            feita_d  = 1'b1;
          end else begin
            inval_d = 1'b1;
          end
        end
      end
      default: begin
        estado_d = SOLTA;
        cnt_d    = '0;
      end
    endcase
  end

  assign jogada          = jogada_q;
  assign jogada_feita    = feita_q;
  assign jogada_invalida = inval_q;
  assign timeout         = timeout_q;
  assign db_estado       = estado_q;

endmodule

// File: tb/tb_detector_jogada.sv
// Bench for detector_jogada with DEBOUNCE_CICLOS=8, TIMEOUT_CICLOS=50; honours DETECTOR_TIMEOUT_EN.
module tb_detector_jogada;
  import detector_jogada_pkg::*;

  localparam int DEB = 8;
  localparam int TMO = 50;
  // Negedges from driving a press (just after a negedge) to the strobe sample.
  localparam int LAT = DEB + 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       habilita;
  logic [3:0] botoes;
  logic [3:0] jogada;
  logic       jogada_feita;
  logic       jogada_invalida;
  logic       timeout;
  logic [2:0] db_estado;

  int n_tests = 0;
  int n_fail  = 0;
  logic [6:0] exp_q[$];
  logic [6:0] ev_got;
  logic [6:0] ev_exp;
  logic [3:0] jogada_modelo;

  typedef struct {
    logic [3:0] botoes;
    logic       feita;
    logic       inval;
    logic [3:0] jogada;
  } vetor_t;
  vetor_t tabela[6];

  detector_jogada #(
    .DEBOUNCE_CICLOS (DEB),
    .TIMEOUT_CICLOS  (TMO)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .habilita        (habilita),
    .botoes          (botoes),
    .jogada          (jogada),
    .jogada_feita    (jogada_feita),
    .jogada_invalida (jogada_invalida),
    .timeout         (timeout),
    .db_estado       (db_estado)
  );

  always #5 clock = ~clock;

  task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nome, got, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest expected event {timeout, feita, invalida, jogada}.
  always @(negedge clock) begin
    if (!reset && (timeout || jogada_feita || jogada_invalida)) begin
      ev_got = {timeout, jogada_feita, jogada_invalida, jogada};
      if (exp_q.size() == 0) begin
        check("evento_inesperado", 32'(ev_got), 32'd0);
      end else begin
        ev_exp = exp_q.pop_front();
        check("evento", 32'(ev_got), 32'(ev_exp));
      end
    end
  end

  task automatic ciclos(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Drives a level for 'hold' negedges, measuring first strobe position and strobe count.
  task automatic aplica(input logic [3:0] pat, input int hold, output int lat, output int pulsos);
    lat    = -1;
    pulsos = 0;
    botoes = pat;
    for (int k = 1; k <= hold; k++) begin
      @(negedge clock);
      if (jogada_feita || jogada_invalida) begin
        pulsos++;
        if (lat < 0) lat = k;
      end
    end
  endtask

  task automatic solta_botoes;
    botoes = 4'b0000;
    ciclos(12);
  endtask

  task automatic espera_jogada(input logic [3:0] pat, input string nome);
    int  lat, pulsos;
    logic ok;
    ok = ($countones(pat) == 1);
    exp_q.push_back({1'b0, ok, !ok, ok ? pat : jogada_modelo});
    if (ok) jogada_modelo = pat;
    aplica(pat, 20, lat, pulsos);
    check({nome, "_pulsos"}, 32'(pulsos), 32'd1);
    check({nome, "_latencia"}, 32'(lat), 32'(LAT));
    check({nome, "_jogada"}, 32'(jogada), 32'(jogada_modelo));
    solta_botoes();
  endtask

  initial begin
    int lat, pulsos, n_tmo, lat_tmo;
    logic [3:0] pat;

    tabela[0] = '{4'b0001, 1'b1, 1'b0, 4'b0001};
    tabela[1] = '{4'b0110, 1'b0, 1'b1, 4'b0001};
    tabela[2] = '{4'b1000, 1'b1, 1'b0, 4'b1000};
    tabela[3] = '{4'b1111, 1'b0, 1'b1, 4'b1000};
    tabela[4] = '{4'b0100, 1'b1, 1'b0, 4'b0100};
    tabela[5] = '{4'b1010, 1'b0, 1'b1, 4'b0100};

    // Reset values
    reset = 1'b1; habilita = 1'b1; botoes = 4'b0000; jogada_modelo = 4'b0000;
    ciclos(3);
    check("reset_jogada", 32'(jogada), 32'd0);
    check("reset_feita", 32'(jogada_feita), 32'd0);
    check("reset_invalida", 32'(jogada_invalida), 32'd0);
    check("reset_timeout", 32'(timeout), 32'd0);
    check("reset_estado", 32'(db_estado), 32'(SOLTA));
    reset = 1'b0;
    ciclos(10);
    check("idle_espera", 32'(db_estado), 32'(ESPERA));

    // Basic valid press with exact latency, then release timing back to ESPERA
    exp_q.push_back({3'b010, 4'b0100});
    jogada_modelo = 4'b0100;
    aplica(4'b0100, 20, lat, pulsos);
    check("basica_pulsos", 32'(pulsos), 32'd1);
    check("basica_latencia", 32'(lat), 32'(LAT));
    check("basica_jogada", 32'(jogada), 32'h4);
    check("basica_solta", 32'(db_estado), 32'(SOLTA));
    botoes = 4'b0000;
    ciclos(9);
    check("soltura_ainda_solta", 32'(db_estado), 32'(SOLTA));
    ciclos(1);
    check("soltura_espera", 32'(db_estado), 32'(ESPERA));
    ciclos(2);

    // Bounce before the stable level: one strobe, timed from the stable level
    aplica(4'b0010, 3, lat, pulsos);
    aplica(4'b0000, 2, lat, pulsos);
    exp_q.push_back({3'b010, 4'b0010});
    jogada_modelo = 4'b0010;
    aplica(4'b0010, 20, lat, pulsos);
    check("bounce_pulsos", 32'(pulsos), 32'd1);
    check("bounce_latencia", 32'(lat), 32'(LAT));
    solta_botoes();

    // Non-one-hot press: invalid strobe, jogada unchanged
    exp_q.push_back({3'b001, 4'b0010});
    aplica(4'b0011, 20, lat, pulsos);
    check("invalida_pulsos", 32'(pulsos), 32'd1);
    check("invalida_latencia", 32'(lat), 32'(LAT));
    check("invalida_jogada", 32'(jogada), 32'h2);
    solta_botoes();

    // Table vectors
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({1'b0, tabela[i].feita, tabela[i].inval, tabela[i].jogada});
      aplica(tabela[i].botoes, 20, lat, pulsos);
      check($sformatf("tabela%0d_pulsos", i), 32'(pulsos), 32'd1);
      check($sformatf("tabela%0d_latencia", i), 32'(lat), 32'(LAT));
      check($sformatf("tabela%0d_jogada", i), 32'(jogada), 32'(tabela[i].jogada));
      solta_botoes();
    end
    jogada_modelo = tabela[5].jogada;

    // Random patterns against the bench's own one-hot model
    for (int i = 0; i < 4; i++) begin
      pat = 4'($urandom_range(1, 15));
      espera_jogada(pat, $sformatf("aleatorio%0d", i));
    end

    // Button held through reset: no strobe until released and pressed again
    botoes = 4'b1000;
    reset = 1'b1;
    ciclos(3);
    check("reset2_jogada", 32'(jogada), 32'd0);
    jogada_modelo = 4'b0000;
    reset = 1'b0;
    aplica(4'b1000, 30, lat, pulsos);
    check("preso_pulsos", 32'(pulsos), 32'd0);
    check("preso_estado", 32'(db_estado), 32'(SOLTA));
    solta_botoes();
    check("preso_soltou", 32'(db_estado), 32'(ESPERA));
    espera_jogada(4'b1000, "preso_nova");

    // habilita drops in FILTRA: abort, and a continued press is ignored
    aplica(4'b0001, 6, lat, pulsos);
    check("aborto_filtra", 32'(db_estado), 32'(FILTRA));
    habilita = 1'b0;
    ciclos(2);
    check("aborto_estado", 32'(db_estado), 32'(SOLTA));
    habilita = 1'b1;
    aplica(4'b0001, 20, lat, pulsos);
    check("aborto_pulsos", 32'(pulsos), 32'd0);
    check("aborto_segura", 32'(db_estado), 32'(SOLTA));
    solta_botoes();
    check("aborto_espera", 32'(db_estado), 32'(ESPERA));

    // habilita=0 in ESPERA: press ignored
    habilita = 1'b0;
    aplica(4'b0100, 15, lat, pulsos);
    check("desab_pulsos", 32'(pulsos), 32'd0);
    check("desab_estado", 32'(db_estado), 32'(ESPERA));
    botoes = 4'b0000;
    ciclos(3);

    // Idle timeout
`ifdef DETECTOR_TIMEOUT_EN
    exp_q.push_back({3'b100, jogada_modelo});
`endif
    habilita = 1'b1;
    n_tmo = 0;
    lat_tmo = -1;
    for (int k = 1; k <= 2 * TMO + 20; k++) begin
      @(negedge clock);
      if (timeout) begin
        n_tmo++;
        if (lat_tmo < 0) lat_tmo = k;
      end
    end
`ifdef DETECTOR_TIMEOUT_EN
    check("timeout_pulsos", 32'(n_tmo), 32'd1);
    check("timeout_latencia", 32'(lat_tmo), 32'(TMO));
`else
    check("timeout_ausente", 32'(n_tmo), 32'd0);
`endif
    check("timeout_estado", 32'(db_estado), 32'(ESPERA));

    check("fila_vazia", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
